btb_update_ctrl: RTL

- Write-side controller for the direct-mapped branch target buffer. Accepts up to two resolved control-flow records per cycle from the execute branch units.
- Detects mispredictions and issues a registered fetch redirect.
- Queues records that need a BTB allocation or correction, and drains them one per cycle onto the BTB single write port (update_btb / ex_pc / actual_target_address / ex_is_ret / ex_is_branch).

---
 rtl/btb_update_ctrl.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/btb_update_ctrl.sv
// btb_update_ctrl: BTB write-side controller with registered mispredict redirect.
// Optional BTB_UPD_COALESCE_EN merges same-PC updates into the newest queue entry.
module btb_update_ctrl #(
    parameter int XLEN   = 32,
    parameter int QDEPTH = 4
) (
    input  logic            CLK,
    input  logic            reset,
    input  logic            flush,
    input  logic            res_valid0,
    input  logic            res_valid1,
    input  logic [XLEN-1:0] res_pc0,
    input  logic [XLEN-1:0] res_pc1,
    input  logic            res_taken0,
    input  logic            res_taken1,
    input  logic [XLEN-1:0] res_target0,
    input  logic [XLEN-1:0] res_target1,
    input  logic            res_pred_taken0,
    input  logic            res_pred_taken1,
    input  logic [XLEN-1:0] res_pred_target0,
    input  logic [XLEN-1:0] res_pred_target1,
    input  logic            res_btb_hit0,
    input  logic            res_btb_hit1,
    input  logic            res_is_ret0,
    input  logic            res_is_ret1,
    input  logic            res_is_branch0,
    input  logic            res_is_branch1,
    output logic            res_ready,
    output logic            update_btb,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] actual_target_address,
    output logic            ex_is_ret,
    output logic            ex_is_branch,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc
);
    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] tgt;
        logic            ret;
        logic            br;
    } ent_t;

    ent_t [QDEPTH-1:0] mem_q, mem_d;
    logic [PW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              upd_q, upd_d;
    ent_t              out_q, out_d;
    logic              rv_q, rv_d;
    logic [XLEN-1:0]   rpc_q, rpc_d;

    logic accept, acc0, acc1, mis0, mis1, nu0, nu1;
    logic push0, push1, pop, alloc0, alloc1;
    ent_t rec0, rec1;

    assign res_ready = count_q <= CW'(QDEPTH - 2);

    always_comb begin
        mis0   = (res_pred_taken0 != res_taken0) ||
                 (res_taken0 && res_pred_target0 != res_target0);
        mis1   = (res_pred_taken1 != res_taken1) ||
                 (res_taken1 && res_pred_target1 != res_target1);
        nu0    = res_taken0 && (!res_btb_hit0 || res_pred_target0 != res_target0);
        nu1    = res_taken1 && (!res_btb_hit1 || res_pred_target1 != res_target1);
        accept = res_ready && !flush;
        acc0   = accept && res_valid0;
        // a mispredicting older record puts port 1 on the wrong path
        acc1   = accept && res_valid1 && !(acc0 && mis0);
        push0  = acc0 && nu0;
        push1  = acc1 && nu1;
        pop    = (count_q != '0) && !flush;
        rec0   = '{pc: res_pc0, tgt: res_target0, ret: res_is_ret0, br: res_is_branch0};
        rec1   = '{pc: res_pc1, tgt: res_target1, ret: res_is_ret1, br: res_is_branch1};
    end

    always_comb begin
        rv_d  = 1'b0;
        rpc_d = rpc_q;
        if (acc0 && mis0) begin
            rv_d  = 1'b1;
            rpc_d = res_taken0 ? res_target0 : res_pc0 + XLEN'(4);
        end else if (acc1 && mis1) begin
            rv_d  = 1'b1;
            rpc_d = res_taken1 ? res_target1 : res_pc1 + XLEN'(4);
        end
    end

`ifdef BTB_UPD_COALESCE_EN
    logic [PW-1:0] newest;
    logic          tail_ok, same01, keep0, hit0, hit1;
`endif

    always_comb begin
        mem_d  = mem_q;
        alloc0 = push0;
        alloc1 = push1;
`ifdef BTB_UPD_COALESCE_EN
        newest  = wptr_q - PW'(1);
        // the head leaving this cycle cannot absorb a new record
        tail_ok = (count_q != '0) && !(pop && count_q == CW'(1));
        same01  = push0 && push1 && (res_pc0 == res_pc1);
        keep0   = push0 && !same01;
        hit0    = keep0 && tail_ok && (res_pc0 == mem_q[newest].pc);
        hit1    = push1 && !keep0 && tail_ok && (res_pc1 == mem_q[newest].pc);
        alloc0  = keep0 && !hit0;
        alloc1  = push1 && !hit1;
        if (hit0) mem_d[newest] = rec0;
        if (hit1) mem_d[newest] = rec1;
`endif
        if (alloc0) mem_d[wptr_q] = rec0;
        if (alloc1) mem_d[wptr_q + PW'(alloc0)] = rec1;
        count_d = flush ? '0 : count_q + CW'(alloc0) + CW'(alloc1) - CW'(pop);
        wptr_d  = flush ? '0 : wptr_q + PW'(alloc0) + PW'(alloc1);
        rptr_d  = flush ? '0 : rptr_q + PW'(pop);
        upd_d   = pop;
        out_d   = pop ? mem_q[rptr_q] : out_q;
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            mem_q   <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            upd_q   <= 1'b0;
            out_q   <= '0;
            rv_q    <= 1'b0;
            rpc_q   <= '0;
        end else begin
            mem_q   <= mem_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            upd_q   <= upd_d;
            out_q   <= out_d;
            rv_q    <= rv_d;
            rpc_q   <= rpc_d;
        end
    end

    assign update_btb            = upd_q;
    assign ex_pc                 = out_q.pc;
    assign actual_target_address = out_q.tgt;
    assign ex_is_ret             = out_q.ret;
    assign ex_is_branch          = out_q.br;
    assign redirect_valid        = rv_q;
    assign redirect_pc           = rpc_q;

endmodule
